serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing D = A − B − Bin, one bit per clock, LSB first.
- Uses the borrow-chain counterpart of the team's 1-bit full-adder cell.
- A start/busy/done handshake accepts the operands; results are registered and held until the next operation.
- Trades area for latency in the datapath labs; it is the subtraction end of the adder path.

---
 rtl/serial_subtractor.sv | 102 ++++++++++
 tb/tb_serial_subtractor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Borrow-chain counterpart of the 1-bit full-adder cell, wrapped in a start/busy/done FSM.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         borrow_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic         zero,
  output logic         overflow,
  output logic [1:0]   dbg_state
);

  // Handshake: start is accepted only in IDLE; busy marks the N SHIFT cycles,
  // done is a one-cycle pulse after the last bit, and the result registers
  // hold until the next completion. start outside IDLE is dropped, not queued.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state_q;
  logic [N-1:0]  a_q, b_q, res_q, res_d;
  logic [CW-1:0] cnt_q;
  logic          bw_q, bw_d;
  logic          a_bit, b_bit, d_bit;
  logic [N-1:0]  diff_q;
  logic          borrow_q, zero_q, ovf_q;

  // Full-subtractor cell on the current LSBs of the shifting operands.
  always_comb begin
    a_bit = a_q[0];
    b_bit = b_q[0];
    d_bit = a_bit ^ b_bit ^ bw_q;
    bw_d  = (~a_bit & b_bit) | (~a_bit & bw_q) | (b_bit & bw_q);
    res_d = {d_bit, res_q[N-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            bw_q    <= borrow_in;
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          bw_q  <= bw_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // On the last bit the operand LSBs are the original sign bits.
            diff_q   <= res_d;
            borrow_q <= bw_d;
            zero_q   <= (res_d == '0);
            ovf_q    <= (a_bit != b_bit) && (d_bit != a_bit);
            cnt_q    <= '0;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign zero       = zero_q;
  assign overflow   = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a_in, b_in;
  logic         bin_in;
  logic         busy, done;
  logic [N-1:0] diff;
  logic         borrow_out, zero, overflow;
  logic [1:0]   dbg_state;

  int vectors = 0;
  int fails   = 0;

  // expected {overflow, zero, borrow_out, diff}
  logic [N+2:0] exp_q[$];
  logic [N+2:0] last_res;

  serial_subtractor #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a_in), .b(b_in), .borrow_in(bin_in),
    .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .zero(zero), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [N+2:0] model(input int a, input int b, input int bin);
    int d, sa, sb, sd, m;
    logic [N-1:0] dv;
    logic ovf, brw, zr;
    m   = 1 << N;
    d   = a - b - bin;
    brw = (d < 0);
    dv  = N'((d + 2 * m) % m);
    zr  = (dv == 0);
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    sd  = sa - sb - bin;
    ovf = (sd < -(m / 2)) || (sd > m / 2 - 1);
    return {ovf, zr, brw, dv};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [N+2:0] e);
    check({tag, "_diff"}, 32'(diff), 32'(e[N-1:0]));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(e[N]));
    check({tag, "_zero"}, 32'(zero), 32'(e[N+1]));
    check({tag, "_ovf"}, 32'(overflow), 32'(e[N+2]));
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       input bit inject);
    logic [N+2:0] e;
    a_in = a; b_in = b; bin_in = bin; start = 1'b1;
    exp_q.push_back(model(int'(a), int'(b), int'(bin)));
    @(negedge clk);
    start = 1'b0;
    a_in = N'($urandom); b_in = N'($urandom); bin_in = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      if (inject && i >= 1) begin
        start = 1'b1; a_in = 1; b_in = 1; bin_in = 1'b0;
      end
      check("busy_shift", 32'(busy), 32'd1);
      check("done_shift", 32'(done), 32'd0);
      @(negedge clk);
    end
    check("busy_done", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      check("exp_q_nonempty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check_result("result", e);
    @(negedge clk);
    start = 1'b0;
    check("done_low", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check_result("hold", e);
    last_res = e;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0;
    last_res = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_result("rst", '0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4'd7, 4'd3, 1'b0, 1'b0);
    do_op(4'd3, 4'd7, 1'b0, 1'b0);
    do_op(4'h8, 4'd1, 1'b0, 1'b0);
    do_op(4'd5, 4'd5, 1'b0, 1'b0);
    do_op(4'd0, 4'd0, 1'b1, 1'b0);

    // Start during SHIFT/DONE must be dropped; results hold in IDLE.
    do_op(4'd7, 4'd3, 1'b0, 1'b1);
    a_in = 4'd9; b_in = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_busy", 32'(busy), 32'd0);
      check("idle_no_done", 32'(done), 32'd0);
      check_result("idle_hold", last_res);
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 20; i++)
      do_op(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'b0);

    // Preload a nonzero result, then reset during the 2nd SHIFT cycle.
    do_op(4'd3, 4'd7, 1'b0, 1'b0);
    a_in = 4'd7; b_in = 4'd3; bin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check_result("mid_rst", '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    do_op(4'd2, 4'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
